instruction_fetch_stage: RTL and testbench

Instruction fetch stage and IF/ID pipeline register for the pipelined MIPS datapath. It holds the PC and addresses the synchronous instruction memory. It registers each fetched word with PC+4 into IF/ID, whose opcode and funct fields feed the decode-stage control unit directly. It also handles hazard stalls, branch redirect/flush, halting on the end-of-program opcode and single-step fetch for the debug unit.

---
 rtl/instruction_fetch_stage_if.sv | 18 +
 rtl/instruction_fetch_stage.sv | 141 ++++++++++++++
 tb/tb_instruction_fetch_stage.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_stage_if.sv
// Instruction memory bus between the fetch stage and a synchronous ROM.
// The fetch stage drives the word address; data returns one cycle later.
interface instruction_fetch_stage_if #(
  parameter int ADDR_WIDTH = 10
);
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_rdata;

  modport master (
    output imem_addr,
    input  imem_rdata
  );

  modport slave (
    input  imem_addr,
    output imem_rdata
  );
endinterface

// File: rtl/instruction_fetch_stage.sv
// MIPS fetch stage: PC, IF/ID register, stall/flush, EOP halt and
// single-step control for the debug unit.
module instruction_fetch_stage #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        run_mode,
  input  logic        step,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  instruction_fetch_stage_if.master imem,
  output logic [31:0] pc,
  output logic [31:0] if_id_instr,
  output logic [5:0]  if_id_opcode,
  output logic [5:0]  if_id_funct,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic        halted,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_STEP,
    S_HALT
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  state_t      w_mode_st;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_pc4;
  logic        r_valid;
  logic [31:0] r_count;
  logic        r_step_pend;
  logic        w_advance;
  logic        w_eop;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_next_pc;

  assign w_mode_st  = run_mode ? S_RUN : S_STEP;
  assign w_pc_plus4 = r_pc + 32'd4;

  assign w_advance = !stall &&
    ((r_state == S_RUN) ||
     ((r_state == S_STEP) && (step || r_step_pend)));

  // A taken branch squashes the EOP, so it never halts.
  assign w_eop = w_advance && !branch_taken &&
    (imem.imem_rdata[31:26] == 6'h3f);

  always_comb begin
    w_next_pc = r_pc;
    unique case (1'b1)
      branch_taken:
        w_next_pc = branch_target;
      (w_advance && !branch_taken):
        w_next_pc = w_pc_plus4;
      default:
        w_next_pc = r_pc;
    endcase
  end

  // Addressing with next-PC keeps rdata aligned to the registered PC.
  assign imem.imem_addr = w_next_pc[ADDR_WIDTH+1:2];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_BOOT;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_BOOT:
        w_state_nxt = w_mode_st;
      S_RUN, S_STEP:
        w_state_nxt = w_eop ? S_HALT : w_mode_st;
      S_HALT:
        w_state_nxt = branch_taken ? w_mode_st : S_HALT;
      default:
        w_state_nxt = S_BOOT;
    endcase
  end

  always_comb begin
    halted         = (r_state == S_HALT);
    pc             = r_pc;
    if_id_instr    = r_instr;
    if_id_opcode   = r_instr[31:26];
    if_id_funct    = r_instr[5:0];
    if_id_pc_plus4 = r_pc4;
    if_id_valid    = r_valid;
    fetch_count    = r_count;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pc <= 32'd0;
    end else begin
      r_pc <= w_next_pc;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_step_pend <= 1'b0;
    end else if (w_advance || w_eop) begin
      r_step_pend <= 1'b0;
    end else if ((r_state == S_STEP) && step && stall) begin
      r_step_pend <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_instr <= 32'd0;
      r_pc4   <= 32'd0;
      r_valid <= 1'b0;
      r_count <= 32'd0;
    end else if (branch_taken) begin
      r_instr <= 32'd0;
      r_valid <= 1'b0;
    end else if (stall) begin
      r_instr <= r_instr;
    end else if (w_advance) begin
      r_instr <= imem.imem_rdata;
      r_pc4   <= w_pc_plus4;
      r_valid <= 1'b1;
      r_count <= r_count + 32'd1;
    end else begin
      r_instr <= 32'd0;
      r_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Scoreboard bench for instruction_fetch_stage: directed fetch, stall,
// branch, EOP halt, single-step and async reset scenarios.
module tb_instruction_fetch_stage;
  localparam int AW = 10;

  localparam logic [31:0] I_ADDI = 32'h20010005;
  localparam logic [31:0] I_ADD  = 32'h00221820;
  localparam logic [31:0] I_SW   = 32'hAC030000;
  localparam logic [31:0] I_W3   = 32'h20040007;
  localparam logic [31:0] I_W4   = 32'h20050008;
  localparam logic [31:0] I_EOP  = 32'hFC000000;
  localparam logic [31:0] I_W16  = 32'h20060010;
  localparam logic [31:0] I_W17  = 32'h20070011;
  localparam logic [31:0] I_W18  = 32'h20080012;
  localparam logic [31:0] I_W19  = 32'h20090013;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        run_mode;
  logic        step;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] pc;
  logic [31:0] if_id_instr;
  logic [5:0]  if_id_opcode;
  logic [5:0]  if_id_funct;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;
  logic        halted;
  logic [31:0] fetch_count;

  logic [31:0] mem [0:1023];

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  logic last_ok = 1'b0;

  always #5 clk = ~clk;

  instruction_fetch_stage_if #(.ADDR_WIDTH(AW)) imem ();

  instruction_fetch_stage #(.ADDR_WIDTH(AW)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .run_mode       (run_mode),
    .step           (step),
    .stall          (stall),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .imem           (imem),
    .pc             (pc),
    .if_id_instr    (if_id_instr),
    .if_id_opcode   (if_id_opcode),
    .if_id_funct    (if_id_funct),
    .if_id_pc_plus4 (if_id_pc_plus4),
    .if_id_valid    (if_id_valid),
    .halted         (halted),
    .fetch_count    (fetch_count)
  );

  always @(posedge clk) imem.imem_rdata <= mem[imem.imem_addr];

  // New IF/ID contents only appear after an unstalled edge.
  always @(posedge clk) last_ok <= !stall;

  always @(negedge clk) begin
    if (reset_n && if_id_valid && last_ok) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL ifid_unexpected: got instr=%h pc4=%h, required no valid",
                 if_id_instr, if_id_pc_plus4);
      end else begin
        e = q.pop_front();
        if (if_id_instr !== e.instr || if_id_pc_plus4 !== e.pc4 ||
            if_id_opcode !== e.instr[31:26] || if_id_funct !== e.instr[5:0]) begin
          errors++;
          $display("FAIL ifid_word: got instr=%h pc4=%h op=%h fn=%h, required instr=%h pc4=%h",
                   if_id_instr, if_id_pc_plus4, if_id_opcode, if_id_funct,
                   e.instr, e.pc4);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] instr, input logic [31:0] pc4);
    exp_t x;
    x.instr = instr;
    x.pc4   = pc4;
    q.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_pc"}, pc, 32'd0);
    check({tag, "_instr"}, if_id_instr, 32'd0);
    check({tag, "_pc4"}, if_id_pc_plus4, 32'd0);
    check({tag, "_valid"}, {31'd0, if_id_valid}, 32'd0);
    check({tag, "_halted"}, {31'd0, halted}, 32'd0);
    check({tag, "_count"}, fetch_count, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
    mem[0]  = I_ADDI;
    mem[1]  = I_ADD;
    mem[2]  = I_SW;
    mem[3]  = I_W3;
    mem[4]  = I_W4;
    mem[5]  = I_EOP;
    mem[16] = I_W16;
    mem[17] = I_W17;
    mem[18] = I_W18;
    mem[19] = I_W19;

    reset_n       = 1'b0;
    run_mode      = 1'b1;
    step          = 1'b0;
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'd0;
    repeat (2) tick();
    check_zero("reset");

    reset_n = 1'b1;
    tick();
    check("boot_valid", {31'd0, if_id_valid}, 32'd0);
    check("boot_pc", pc, 32'd0);

    push(I_ADDI, 32'd4);
    push(I_ADD, 32'd8);
    push(I_SW, 32'd12);
    repeat (3) tick();
    check("run3_count", fetch_count, 32'd3);
    check("run3_pc", pc, 32'd12);

    stall = 1'b1;
    #1;
    check("stall_addr0", {22'd0, imem.imem_addr}, 32'd3);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_pc", pc, 32'd12);
      check("stall_count", fetch_count, 32'd3);
      check("stall_addr", {22'd0, imem.imem_addr}, 32'd3);
      check("stall_instr", if_id_instr, I_SW);
    end

    stall = 1'b0;
    push(I_W3, 32'd16);
    push(I_W4, 32'd20);
    push(I_EOP, 32'd24);
    repeat (3) tick();
    check("eop_halted", {31'd0, halted}, 32'd1);
    check("eop_pc", pc, 32'h18);
    check("eop_valid", {31'd0, if_id_valid}, 32'd1);
    check("eop_instr", if_id_instr, I_EOP);
    check("eop_count", fetch_count, 32'd6);
    repeat (2) tick();
    check("halt_bubble", {31'd0, if_id_valid}, 32'd0);
    check("halt_hold", {31'd0, halted}, 32'd1);
    check("halt_pc", pc, 32'h18);

    branch_taken  = 1'b1;
    branch_target = 32'h0;
    #1;
    check("unhalt_addr", {22'd0, imem.imem_addr}, 32'd0);
    tick();
    branch_taken = 1'b0;
    check("unhalt_halted", {31'd0, halted}, 32'd0);
    check("unhalt_valid", {31'd0, if_id_valid}, 32'd0);
    check("unhalt_pc", pc, 32'd0);
    push(I_ADDI, 32'd4);
    tick();

    stall = 1'b1;
    tick();
    check("stall2_instr", if_id_instr, I_ADDI);
    check("stall2_pc", pc, 32'd4);
    branch_taken  = 1'b1;
    branch_target = 32'h40;
    #1;
    check("br_addr", {22'd0, imem.imem_addr}, 32'd16);
    tick();
    branch_taken = 1'b0;
    stall        = 1'b0;
    check("br_flush", {31'd0, if_id_valid}, 32'd0);
    check("br_pc", pc, 32'h40);
    push(I_W16, 32'h44);
    push(I_W17, 32'h48);
    tick();
    run_mode = 1'b0;
    tick();
    check("mode_pc", pc, 32'h48);
    tick();
    check("step_idle", {31'd0, if_id_valid}, 32'd0);
    check("step_idle_pc", pc, 32'h48);
    check("step_idle_count", fetch_count, 32'd9);

    stall = 1'b1;
    step  = 1'b1;
    tick();
    step = 1'b0;
    check("step_stall_pc", pc, 32'h48);
    tick();
    check("step_stall_pc2", pc, 32'h48);
    check("step_stall_valid", {31'd0, if_id_valid}, 32'd0);
    stall = 1'b0;
    push(I_W18, 32'h4C);
    tick();
    check("step_pend_count", fetch_count, 32'd10);
    repeat (2) tick();
    check("step_after_valid", {31'd0, if_id_valid}, 32'd0);
    check("step_after_pc", pc, 32'h4C);
    check("step_after_count", fetch_count, 32'd10);
    step = 1'b1;
    push(I_W19, 32'h50);
    tick();
    step = 1'b0;
    check("step2_count", fetch_count, 32'd11);
    tick();
    check("step2_bubble", {31'd0, if_id_valid}, 32'd0);

    #2;
    reset_n = 1'b0;
    #1;
    check_zero("async");
    run_mode = 1'b1;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    tick();
    check("reboot_valid", {31'd0, if_id_valid}, 32'd0);
    check("reboot_pc", pc, 32'd0);
    push(I_ADDI, 32'd4);
    push(I_ADD, 32'd8);
    repeat (2) tick();
    check("reboot_count", fetch_count, 32'd2);
    stall = 1'b1;
    @(negedge clk);
    #1;
    check("queue_drained", q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
